// File: rtl/vld_req_sequencer.sv
// Vector unit-stride load sequencer: turns one load command into word-aligned
// memory reads, buffers the in-order responses and streams them to the VLU.
module vld_req_sequencer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned WordWidthB     = 8,
  parameter int unsigned VlWidth        = 16,
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [AddrWidth-1:0]    cmd_base_i,
  input  logic [VlWidth-1:0]      cmd_vstart_i,
  input  logic [VlWidth-1:0]      cmd_vl_i,
  input  logic [1:0]              cmd_vew_i,
  input  logic [IdWidth-1:0]      cmd_id_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [AddrWidth-1:0]    mem_req_addr_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [8*WordWidthB-1:0] mem_rsp_data_i,
  output logic                    load_op_valid_o,
  input  logic                    load_op_ready_i,
  output logic [8*WordWidthB-1:0] load_op_o,
  output logic                    done_o,
  output logic [IdWidth-1:0]      done_id_o,
  output logic                    busy_o
);

  localparam int unsigned OffW  = $clog2(WordWidthB);
  localparam int unsigned DataW = 8 * WordWidthB;
  localparam int unsigned MW    = VlWidth + 3;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_next;

  logic [AddrWidth-1:0] r_addr;
  logic [MW-1:0]        r_reqs_left;
  logic [MW-1:0]        r_nwords;
  logic [MW-1:0]        r_delivered;
  logic [IdWidth-1:0]   r_id;
  logic [CntW-1:0]      r_credits;
  logic [CntW-1:0]      r_pending;

  logic [DataW-1:0]     r_buf [MaxOutstanding];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;

  logic [MW-1:0]        w_vstart_b;
  logic [MW-1:0]        w_vl_b;
  logic [MW-1:0]        w_first;
  logic [MW-1:0]        w_ceil;
  logic [MW-1:0]        w_nwords;
  logic [AddrWidth-1:0] w_base_al;
  logic [AddrWidth-1:0] w_start_addr;

  logic w_cmd_hs;
  logic w_req_valid;
  logic w_req_hs;
  logic w_op_valid;
  logic w_op_hs;
  logic w_push;
  logic w_done;

  // Word range covered by the command, in VRF words.
  assign w_vstart_b   = MW'(cmd_vstart_i) << cmd_vew_i;
  assign w_vl_b       = MW'(cmd_vl_i) << cmd_vew_i;
  assign w_first      = w_vstart_b >> OffW;
  assign w_ceil       = (w_vl_b >> OffW) + MW'(|w_vl_b[OffW-1:0]);
  assign w_nwords     = (cmd_vl_i > cmd_vstart_i) ? (w_ceil - w_first) : '0;
  assign w_base_al    = cmd_base_i & ~AddrWidth'(WordWidthB - 1);
  assign w_start_addr = w_base_al + AddrWidth'(w_first << OffW);

  assign w_cmd_hs    = cmd_valid_i && (r_state == S_IDLE);
  assign w_req_valid = (r_state == S_ISSUE) && (r_reqs_left != '0) && (r_credits != '0);
  assign w_req_hs    = w_req_valid && mem_req_ready_i;
  assign w_op_valid  = (r_count != '0);
  assign w_op_hs     = w_op_valid && load_op_ready_i;
  assign w_push      = mem_rsp_valid_i && (r_pending != '0);
  assign w_done      = (r_state == S_DRAIN) && (r_delivered == r_nwords);

  // Outputs are decoded from registered state only.
  assign cmd_ready_o     = (r_state == S_IDLE);
  assign busy_o          = (r_state != S_IDLE);
  assign mem_req_valid_o = w_req_valid;
  assign mem_req_addr_o  = r_addr;
  assign load_op_valid_o = w_op_valid;
  assign load_op_o       = w_op_valid ? r_buf[r_rptr] : '0;
  assign done_o          = w_done;
  assign done_id_o       = w_done ? r_id : '0;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cmd_hs) w_state_next = (w_nwords != '0) ? S_ISSUE : S_DRAIN;
      S_ISSUE: if (w_req_hs && (r_reqs_left == MW'(1))) w_state_next = S_DRAIN;
      S_DRAIN: if (w_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Command bookkeeping, address generation and credit/pending counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr      <= '0;
      r_reqs_left <= '0;
      r_nwords    <= '0;
      r_delivered <= '0;
      r_id        <= '0;
      r_credits   <= CntW'(MaxOutstanding);
      r_pending   <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr      <= w_start_addr;
        r_reqs_left <= w_nwords;
        r_nwords    <= w_nwords;
        r_delivered <= '0;
        r_id        <= cmd_id_i;
      end else begin
        if (w_req_hs) begin
          r_addr      <= r_addr + AddrWidth'(WordWidthB);
          r_reqs_left <= r_reqs_left - MW'(1);
        end
        if (w_op_hs) r_delivered <= r_delivered + MW'(1);
      end
      if (w_req_hs && !w_op_hs)      r_credits <= r_credits - CntW'(1);
      else if (!w_req_hs && w_op_hs) r_credits <= r_credits + CntW'(1);
      if (w_req_hs && !w_push)       r_pending <= r_pending + CntW'(1);
      else if (!w_req_hs && w_push)  r_pending <= r_pending - CntW'(1);
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_op_hs) r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_op_hs)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_op_hs) r_count <= r_count - CntW'(1);
    end
  end

  // Response FIFO storage; contents are only observed while occupied.
  always_ff @(posedge clk_i) begin
    if (w_push) r_buf[r_wptr] <= mem_rsp_data_i;
  end

endmodule

// File: tb/tb_vld_req_sequencer.sv
// Bench for vld_req_sequencer: random memory/VLU timing around directed and
// random load commands, checked each cycle against a queue-based model.
module tb_vld_req_sequencer;
  localparam int AW = 32;
  localparam int WB = 8;
  localparam int VW = 16;
  localparam int IW = 3;
  localparam int MO = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_base_i;
  logic [VW-1:0] cmd_vstart_i;
  logic [VW-1:0] cmd_vl_i;
  logic [1:0]    cmd_vew_i;
  logic [IW-1:0] cmd_id_i;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_rsp_valid_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic          load_op_valid_o;
  logic          load_op_ready_i;
  logic [DW-1:0] load_op_o;
  logic          done_o;
  logic [IW-1:0] done_id_o;
  logic          busy_o;

  always #5 clk = ~clk;

  vld_req_sequencer #(
    .AddrWidth(AW), .WordWidthB(WB), .VlWidth(VW), .IdWidth(IW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_base_i(cmd_base_i),
    .cmd_vstart_i(cmd_vstart_i), .cmd_vl_i(cmd_vl_i), .cmd_vew_i(cmd_vew_i), .cmd_id_i(cmd_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .load_op_valid_o(load_op_valid_o), .load_op_ready_i(load_op_ready_i), .load_op_o(load_op_o),
    .done_o(done_o), .done_id_o(done_id_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] memdata(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  // Reference model state
  bit            m_busy = 0;
  int            m_nwords = 0, m_delivered = 0, m_issued = 0, m_pending = 0;
  logic [IW-1:0] m_id = '0;
  logic [31:0]   m_addr_q[$];
  logic [63:0]   m_exp_q[$];
  logic [63:0]   m_buf[$];
  // Memory model
  logic [63:0]   mq_data[$];
  int            mq_rdy[$];
  // Knobs
  int p_mem_rdy = 100, p_op_rdy = 100, p_rsp = 100, lat_max = 0, stale_cnt = 0;
  bit toggle_rdy = 0, chk_en = 0;
  // Statistics
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, req_cnt = 0, deliv_cmd = 0;
  logic [31:0]   req_log[$];
  int            done_cyc_q[$];
  logic [IW-1:0] done_id_q[$];
  bit            pr_req_stall = 0, pr_op_stall = 0;
  logic [31:0]   pr_addr;
  logic [63:0]   pr_data;

  function automatic logic [31:0] rl(input int k);
    return (req_log.size() > k) ? req_log[k] : 32'hDEAD_BEEF;
  endfunction
  function automatic int dcyc(input int k);
    return (done_cyc_q.size() > k) ? done_cyc_q[k] : -1;
  endfunction
  function automatic int did(input int k);
    return (done_id_q.size() > k) ? int'(done_id_q[k]) : -1;
  endfunction

  // Compare, drive memory/VLU side, then advance the model across the next edge.
  always @(negedge clk) begin
    bit done_now;
    bit e_reqv;
    logic [31:0] a;
    cyc++;
    done_now = m_busy && (m_delivered == m_nwords);
    e_reqv   = m_busy && (m_addr_q.size() > 0) && ((m_issued - m_delivered) < MO);
    if (chk_en) begin
      chk("cmd_ready", 64'(cmd_ready_o), 64'(!m_busy));
      chk("busy", 64'(busy_o), 64'(m_busy));
      chk("req_valid", 64'(mem_req_valid_o), 64'(e_reqv));
      if (e_reqv) chk("req_addr", 64'(mem_req_addr_o), 64'(m_addr_q[0]));
      chk("op_valid", 64'(load_op_valid_o), 64'(m_buf.size() > 0));
      if (m_buf.size() > 0) chk("op_data", load_op_o, m_buf[0]);
      chk("done", 64'(done_o), 64'(done_now));
      chk("done_id", 64'(done_id_o), done_now ? 64'(m_id) : 64'd0);
      if (pr_req_stall) chk("req_hold", {31'd0, mem_req_valid_o, mem_req_addr_o}, {31'd1, pr_addr});
      if (pr_op_stall) chk("op_hold", load_op_o, pr_data);
      if (done_o === 1'b1) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        done_id_q.push_back(done_id_o);
      end
    end
    mem_req_ready_i = toggle_rdy ? cyc[0] : (int'($urandom_range(99)) < p_mem_rdy);
    load_op_ready_i = (int'($urandom_range(99)) < p_op_rdy);
    if (stale_cnt > 0) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = {$urandom, $urandom};
      stale_cnt--;
    end else if (mq_data.size() > 0 && mq_rdy[0] <= cyc && int'($urandom_range(99)) < p_rsp) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = mq_data.pop_front();
      void'(mq_rdy.pop_front());
    end else begin
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = {$urandom, $urandom};
    end
    pr_req_stall = !rst_i && mem_req_valid_o && !mem_req_ready_i;
    pr_addr      = mem_req_addr_o;
    pr_op_stall  = !rst_i && load_op_valid_o && !load_op_ready_i;
    pr_data      = load_op_o;
    if (rst_i) begin
      m_busy = 0; m_nwords = 0; m_delivered = 0; m_issued = 0; m_pending = 0;
      m_addr_q.delete(); m_exp_q.delete(); m_buf.delete();
      mq_data.delete(); mq_rdy.delete();
    end else begin
      if (mem_rsp_valid_i && m_pending > 0) begin
        m_buf.push_back(mem_rsp_data_i);
        m_pending--;
      end
      if (mem_req_valid_o === 1'b1 && mem_req_ready_i) begin
        a = mem_req_addr_o;
        req_log.push_back(a);
        req_cnt++;
        mq_data.push_back(memdata(a));
        mq_rdy.push_back(cyc + 1 + int'($urandom_range(lat_max)));
        if (m_addr_q.size() > 0) void'(m_addr_q.pop_front());
        m_issued++;
        m_pending++;
      end
      if (load_op_valid_o === 1'b1 && load_op_ready_i) begin
        chk("op_order", load_op_o, (m_exp_q.size() > 0) ? m_exp_q.pop_front() : 64'hX);
        if (m_buf.size() > 0) void'(m_buf.pop_front());
        m_delivered++;
        deliv_cmd++;
      end
      if (done_now) m_busy = 0;
      if (cmd_valid_i && cmd_ready_o === 1'b1) begin
        int vsb, vlb, first, lastc;
        logic [31:0] base_al, ad;
        vsb     = int'(cmd_vstart_i) << cmd_vew_i;
        vlb     = int'(cmd_vl_i) << cmd_vew_i;
        first   = vsb / WB;
        lastc   = (vlb + WB - 1) / WB;
        m_nwords = (cmd_vl_i > cmd_vstart_i) ? (lastc - first) : 0;
        base_al = cmd_base_i & ~32'(WB - 1);
        for (int k = 0; k < m_nwords; k++) begin
          ad = base_al + 32'((first + k) * WB);
          m_addr_q.push_back(ad);
          m_exp_q.push_back(memdata(ad));
        end
        m_busy = 1; m_id = cmd_id_i; m_delivered = 0; m_issued = 0;
        acc_cnt++; acc_cyc = cyc; req_cnt = 0; deliv_cmd = 0;
        req_log.delete();
      end
    end
  end

  task automatic send_cmd(input logic [31:0] base, input int vstart, input int vl,
                          input int vew, input int id);
    int snap, n;
    @(posedge clk); #1;
    cmd_base_i   = base;
    cmd_vstart_i = VW'(vstart);
    cmd_vl_i     = VW'(vl);
    cmd_vew_i    = 2'(vew);
    cmd_id_i     = IW'(id);
    cmd_valid_i  = 1'b1;
    snap = acc_cnt;
    n = 0;
    while (acc_cnt == snap && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_valid_i = 1'b0;
    chk("cmd_accepted", 64'(acc_cnt != snap), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", 64'(done_cnt >= target), 64'd1);
  endtask

  initial begin
    int nd;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_base_i = '0; cmd_vstart_i = '0; cmd_vl_i = '0;
    cmd_vew_i = '0; cmd_id_i = '0; mem_req_ready_i = 1'b0; load_op_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_req_addr", 64'(mem_req_addr_o), 64'd0);
    chk("rst_op_valid", 64'(load_op_valid_o), 64'd0);
    chk("rst_op_data", load_op_o, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_done_id", 64'(done_id_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk_en = 1;

    // 8 words from 0x1000, everything ready, single-cycle memory
    send_cmd(32'h1000, 0, 16, 2, 1);
    wait_done(1);
    chk("t1_nreq", 64'(req_cnt), 64'd8);
    chk("t1_first", 64'(rl(0)), 64'h1000);
    chk("t1_last", 64'(rl(7)), 64'h1038);
    chk("t1_done_id", 64'(did(0)), 64'd1);
    chk("t1_latency", 64'(dcyc(0) - acc_cyc), 64'd11);

    // unaligned base, partial first/last word
    send_cmd(32'h1003, 3, 10, 0, 2);
    wait_done(2);
    chk("t2_nreq", 64'(req_cnt), 64'd2);
    chk("t2_a0", 64'(rl(0)), 64'h1000);
    chk("t2_a1", 64'(rl(1)), 64'h1008);
    chk("t2_done_id", 64'(did(1)), 64'd2);

    // credit limit with a stalled consumer
    p_op_rdy = 0;
    send_cmd(32'h2000, 0, 32, 3, 3);
    repeat (30) @(posedge clk);
    #1;
    chk("t3_nreq_stalled", 64'(req_cnt), 64'd4);
    chk("t3_req_valid_low", 64'(mem_req_valid_o), 64'd0);
    chk("t3_op_valid", 64'(load_op_valid_o), 64'd1);
    p_op_rdy = 60; lat_max = 2;
    wait_done(3);
    chk("t3_nreq", 64'(req_cnt), 64'd32);
    chk("t3_ndeliv", 64'(deliv_cmd), 64'd32);

    // zero-word command
    p_op_rdy = 100; lat_max = 0;
    send_cmd(32'h3000, 5, 5, 1, 4);
    wait_done(4);
    chk("t4_nreq", 64'(req_cnt), 64'd0);
    chk("t4_done_delay", 64'(dcyc(3) - acc_cyc), 64'd1);
    chk("t4_ready_after", 64'(cmd_ready_o), 64'd1);

    // back-to-back commands, toggling memory ready
    toggle_rdy = 1; lat_max = 1;
    send_cmd(32'h5000, 2, 12, 2, 5);
    send_cmd(32'h6008, 0, 7, 3, 6);
    chk("t5_second_after_done", 64'(acc_cyc), 64'(dcyc(4) + 1));
    wait_done(6);
    chk("t5_id_a", 64'(did(4)), 64'd5);
    chk("t5_id_b", 64'(did(5)), 64'd6);
    toggle_rdy = 0; lat_max = 0;

    // address wrap at the top of memory
    send_cmd(32'hFFFF_FFF0, 0, 4, 3, 7);
    wait_done(7);
    chk("wrap_a1", 64'(rl(1)), 64'hFFFF_FFF8);
    chk("wrap_a2", 64'(rl(2)), 64'h0);

    // reset mid-command, stale responses afterwards
    send_cmd(32'h4000, 0, 16, 2, 3);
    begin
      int n = 0;
      while (deliv_cmd < 3 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
    end
    nd = done_cnt;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    stale_cnt = 2;
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("t6_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("t6_req_addr", 64'(mem_req_addr_o), 64'd0);
    chk("t6_op_valid", 64'(load_op_valid_o), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_stale_dropped", 64'(load_op_valid_o), 64'd0);
    chk("t6_no_done", 64'(done_cnt), 64'(nd));
    send_cmd(32'h7000, 1, 9, 2, 0);
    wait_done(nd + 1);
    chk("t6_new_id", 64'(did(nd)), 64'd0);
    chk("t6_new_nreq", 64'(req_cnt), 64'd5);

    // random commands and timing
    for (int i = 0; i < 25; i++) begin
      p_mem_rdy = int'($urandom_range(100, 30));
      p_op_rdy  = int'($urandom_range(100, 30));
      p_rsp     = int'($urandom_range(100, 40));
      lat_max   = int'($urandom_range(3));
      nd = done_cnt;
      send_cmd(($urandom_range(7) == 0) ? 32'hFFFF_FFE5 : $urandom,
               int'($urandom_range(20)), int'($urandom_range(40)),
               int'($urandom_range(3)), i);
      wait_done(nd + 1);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
